// File: rtl/vt52_esc_decoder_if.sv
// Byte-in / event-out handshake bundle for the VT52 escape decoder.
// The slave modport is the decoder side; the master modport is the byte source and event sink.
interface vt52_esc_decoder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_code;
    logic [7:0] ev_char;
    logic [4:0] ev_row;
    logic [6:0] ev_col;

    modport slave (
        input  in_data,
        input  in_valid,
        input  ev_ready,
        output in_ready,
        output ev_valid,
        output ev_code,
        output ev_char,
        output ev_row,
        output ev_col
    );

    modport master (
        output in_data,
        output in_valid,
        output ev_ready,
        input  in_ready,
        input  ev_valid,
        input  ev_code,
        input  ev_char,
        input  ev_row,
        input  ev_col
    );
endinterface

// File: rtl/vt52_esc_decoder.sv
// Decodes the VT52 control/escape subset from the USB UART byte stream into one-word terminal events.
// Optional macro VT52_ESC_TIMEOUT_EN abandons a partial escape sequence after TIMEOUT_CYCLES idle cycles.
module vt52_esc_decoder #(
    parameter int ROWS           = 24,
    parameter int COLS           = 80,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic              clk_48mhz,
    input  logic              reset_n,
    vt52_esc_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ESC   = 2'd1,
        Y_ROW = 2'd2,
        Y_COL = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        EV_PUT       = 4'd0,
        EV_CR        = 4'd1,
        EV_LF        = 4'd2,
        EV_BS        = 4'd3,
        EV_TAB       = 4'd4,
        EV_BEL       = 4'd5,
        EV_UP        = 4'd6,
        EV_DOWN      = 4'd7,
        EV_RIGHT     = 4'd8,
        EV_LEFT      = 4'd9,
        EV_HOME      = 4'd10,
        EV_ERASE_EOS = 4'd11,
        EV_ERASE_EOL = 4'd12,
        EV_GOTO      = 4'd13,
        EV_RLF       = 4'd14
    } ev_code_t;

    localparam logic [7:0] CH_BEL = 8'h07;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_ESC = 8'h1B;

    localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
    localparam logic [7:0] COL_MAX = 8'(COLS - 1);

    state_t     state_q, state_d;
    state_t     decodeState;
    logic [4:0] rowLatch_q, rowLatch_d;

    logic       evValid_q, evValid_d;
    logic [3:0] evCode_q, evCode_d;
    logic [7:0] evChar_q, evChar_d;
    logic [4:0] evRow_q, evRow_d;
    logic [6:0] evCol_q, evCol_d;

    logic       inReady;
    logic       accept;

    logic       emit;
    ev_code_t   emitCode;
    logic [7:0] emitChar;
    logic [4:0] emitRow;
    logic [6:0] emitCol;

    // Underflow is taken from the 9th bit before any truncation; clamp happens on the full 8-bit value.
    function automatic logic [7:0] clampCoord(input logic [7:0] b, input logic [7:0] limit);
        logic [8:0] diff;
        diff = {1'b0, b} - 9'h020;
        if (diff[8]) begin
            return 8'h00;
        end else if (diff[7:0] > limit) begin
            return limit;
        end else begin
            return diff[7:0];
        end
    endfunction

    assign inReady = reset_n & (~evValid_q | bus.ev_ready);
    assign accept  = bus.in_valid & inReady;

`ifdef VT52_ESC_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] idleCnt_q, idleCnt_d;
    logic             timeoutFire;

    // A firing timeout makes this cycle decode as IDLE, so a byte arriving now starts fresh.
    assign timeoutFire = (state_q != IDLE) && (idleCnt_q >= TO_LIMIT);
    assign decodeState = timeoutFire ? IDLE : state_q;

    always_comb begin
        idleCnt_d = idleCnt_q + CNT_W'(1);
        if (accept || (decodeState == IDLE)) begin
            idleCnt_d = '0;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            idleCnt_q <= '0;
        end else begin
            idleCnt_q <= idleCnt_d;
        end
    end
`else
    assign decodeState = state_q;
`endif

    always_comb begin
        state_d    = decodeState;
        rowLatch_d = rowLatch_q;
        emit       = 1'b0;
        emitCode   = EV_PUT;
        emitChar   = 8'h00;
        emitRow    = 5'h00;
        emitCol    = 7'h00;

        if (accept) begin
            unique case (decodeState)
                IDLE: begin
                    if ((bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E)) begin
                        emit     = 1'b1;
                        emitCode = EV_PUT;
                        emitChar = bus.in_data;
                    end else begin
                        case (bus.in_data)
                            CH_CR:  begin emit = 1'b1; emitCode = EV_CR;  end
                            CH_LF:  begin emit = 1'b1; emitCode = EV_LF;  end
                            CH_BS:  begin emit = 1'b1; emitCode = EV_BS;  end
                            CH_TAB: begin emit = 1'b1; emitCode = EV_TAB; end
                            CH_BEL: begin emit = 1'b1; emitCode = EV_BEL; end
                            CH_ESC: state_d = ESC;
                            default: ;
                        endcase
                    end
                end
                ESC: begin
                    state_d = IDLE;
                    case (bus.in_data)
                        8'h41:  begin emit = 1'b1; emitCode = EV_UP;        end
                        8'h42:  begin emit = 1'b1; emitCode = EV_DOWN;      end
                        8'h43:  begin emit = 1'b1; emitCode = EV_RIGHT;     end
                        8'h44:  begin emit = 1'b1; emitCode = EV_LEFT;      end
                        8'h48:  begin emit = 1'b1; emitCode = EV_HOME;      end
                        8'h4A:  begin emit = 1'b1; emitCode = EV_ERASE_EOS; end
                        8'h4B:  begin emit = 1'b1; emitCode = EV_ERASE_EOL; end
                        8'h49:  begin emit = 1'b1; emitCode = EV_RLF;       end
                        8'h59:  state_d = Y_ROW;
                        CH_ESC: state_d = ESC;
                        default: ;
                    endcase
                end
                Y_ROW: begin
                    rowLatch_d = 5'(clampCoord(bus.in_data, ROW_MAX));
                    state_d    = Y_COL;
                end
                Y_COL: begin
                    emit     = 1'b1;
                    emitCode = EV_GOTO;
                    emitRow  = rowLatch_q;
                    emitCol  = 7'(clampCoord(bus.in_data, COL_MAX));
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A new event may overwrite the held one only because accept implies the held one is retiring.
    always_comb begin
        evValid_d = evValid_q & ~bus.ev_ready;
        evCode_d  = evCode_q;
        evChar_d  = evChar_q;
        evRow_d   = evRow_q;
        evCol_d   = evCol_q;
        if (emit) begin
            evValid_d = 1'b1;
            evCode_d  = emitCode;
            evChar_d  = emitChar;
            evRow_d   = emitRow;
            evCol_d   = emitCol;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rowLatch_q <= 5'h00;
            evValid_q  <= 1'b0;
            evCode_q   <= 4'h0;
            evChar_q   <= 8'h00;
            evRow_q    <= 5'h00;
            evCol_q    <= 7'h00;
        end else begin
            state_q    <= state_d;
            rowLatch_q <= rowLatch_d;
            evValid_q  <= evValid_d;
            evCode_q   <= evCode_d;
            evChar_q   <= evChar_d;
            evRow_q    <= evRow_d;
            evCol_q    <= evCol_d;
        end
    end

    assign bus.in_ready = inReady;
    assign bus.ev_valid = evValid_q;
    assign bus.ev_code  = evCode_q;
    assign bus.ev_char  = evChar_q;
    assign bus.ev_row   = evRow_q;
    assign bus.ev_col   = evCol_q;

endmodule

// File: tb/tb_vt52_esc_decoder.sv
// Self-checking bench for vt52_esc_decoder: directed test-plan steps, then randomized traffic,
// all checked cycle by cycle against a sequence-level VT52 model kept in the bench.
module tb_vt52_esc_decoder;

    localparam int ROWS    = 24;
    localparam int COLS    = 80;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset_n;

    vt52_esc_decoder_if bus ();

    vt52_esc_decoder #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_48mhz(clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference state: the bytes of a pending escape sequence plus the expected output register.
    logic [7:0] seq[$];
    int         idleCycles = 0;
    bit         expValid   = 0;
    logic [3:0] expCode    = 0;
    logic [7:0] expChar    = 0;
    logic [4:0] expRow     = 0;
    logic [6:0] expCol     = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampInt(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic modelByte(input logic [7:0] b, output bit got, output logic [3:0] code,
                             output logic [7:0] ch, output logic [4:0] row, output logic [6:0] col);
        got = 0; code = 0; ch = 0; row = 0; col = 0;
        case (seq.size())
            0: begin
                if (b >= 8'h20 && b <= 8'h7E) begin got = 1; code = 0; ch = b; end
                else if (b == 8'h0D) begin got = 1; code = 1; end
                else if (b == 8'h0A) begin got = 1; code = 2; end
                else if (b == 8'h08) begin got = 1; code = 3; end
                else if (b == 8'h09) begin got = 1; code = 4; end
                else if (b == 8'h07) begin got = 1; code = 5; end
                else if (b == 8'h1B) seq.push_back(b);
            end
            1: begin
                seq.delete();
                case (b)
                    "A": begin got = 1; code = 6;  end
                    "B": begin got = 1; code = 7;  end
                    "C": begin got = 1; code = 8;  end
                    "D": begin got = 1; code = 9;  end
                    "H": begin got = 1; code = 10; end
                    "J": begin got = 1; code = 11; end
                    "K": begin got = 1; code = 12; end
                    "I": begin got = 1; code = 14; end
                    "Y": begin seq.push_back(8'h1B); seq.push_back(b); end
                    8'h1B: seq.push_back(b);
                    default: ;
                endcase
            end
            2: seq.push_back(b);
            default: begin
                got  = 1;
                code = 13;
                row  = 5'(clampInt(int'(seq[2]) - 32, ROWS - 1));
                col  = 7'(clampInt(int'(b) - 32, COLS - 1));
                seq.delete();
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit v, input bit r, input bit rst);
        bit         expReady, acc, got;
        logic [3:0] c;
        logic [7:0] ch;
        logic [4:0] rw;
        logic [6:0] cl;
        @(negedge clk);
        reset_n      = rst;
        bus.in_data  = d;
        bus.in_valid = v;
        bus.ev_ready = r;
        #1;
        expReady = rst && (!expValid || r);
        checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
        acc = v && expReady;
        @(posedge clk);
        #1;
        if (!rst) begin
            seq.delete();
            idleCycles = 0;
            expValid = 0; expCode = 0; expChar = 0; expRow = 0; expCol = 0;
        end else begin
`ifdef VT52_ESC_TIMEOUT_EN
            if (seq.size() != 0 && idleCycles >= TIMEOUT) seq.delete();
`endif
            got = 0;
            if (acc) modelByte(d, got, c, ch, rw, cl);
            if (acc || seq.size() == 0) idleCycles = 0;
            else idleCycles++;
            if (got) begin
                expValid = 1; expCode = c; expChar = ch; expRow = rw; expCol = cl;
            end else if (r) begin
                expValid = 0;
            end
        end
        checkOutput("ev_valid", 32'(bus.ev_valid), 32'(expValid));
        if (expValid || !rst) begin
            checkOutput("ev_code", 32'(bus.ev_code), 32'(expCode));
            checkOutput("ev_char", 32'(bus.ev_char), 32'(expChar));
            checkOutput("ev_row",  32'(bus.ev_row),  32'(expRow));
            checkOutput("ev_col",  32'(bus.ev_col),  32'(expCol));
        end
    endtask

    task automatic sendBytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) applyStimulus(bytes[i], 1, 1, 1);
    endtask

    initial begin
        logic [7:0] d;
        bit         v, r;
        int         kind;

        reset_n      = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.ev_ready = 1'b0;

        $display("[TB] reset");
        applyStimulus(8'h41, 1, 1, 0);
        applyStimulus(8'h41, 1, 1, 0);
        applyStimulus(8'h00, 0, 1, 1);

        $display("[TB] printable and control bytes");
        sendBytes('{8'h48, 8'h69, 8'h0D, 8'h0A, 8'h08, 8'h09, 8'h07, 8'h20, 8'h7E, 8'h7F, 8'h00, 8'h1F});
        applyStimulus(8'h00, 0, 1, 1);

        $display("[TB] cursor goto and clamps");
        sendBytes('{8'h1B, "Y", 8'h25, 8'h2A});
        sendBytes('{8'h1B, "Y", 8'h7F, 8'h10});
        sendBytes('{8'h1B, "Y", 8'h1B, 8'hFF});
        applyStimulus(8'h00, 0, 1, 1);

        $display("[TB] backpressure");
        applyStimulus("A", 1, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus("B", 1, 0, 1);
        applyStimulus("B", 1, 1, 1);
        applyStimulus(8'h00, 0, 1, 1);

        $display("[TB] escape letters and aborts");
        sendBytes('{8'h1B, "Z", "x", 8'h1B, 8'h1B, "K"});
        sendBytes('{8'h1B, "A", 8'h1B, "B", 8'h1B, "C", 8'h1B, "D"});
        sendBytes('{8'h1B, "H", 8'h1B, "J", 8'h1B, "I"});
        applyStimulus(8'h00, 0, 1, 1);

        $display("[TB] reset mid-sequence");
        sendBytes('{8'h1B, "Y", 8'h25});
        applyStimulus(8'h00, 0, 1, 0);
        applyStimulus(8'h00, 0, 1, 0);
        sendBytes('{"q"});
        applyStimulus(8'h00, 0, 1, 1);

        $display("[TB] idle inside escape");
        applyStimulus(8'h1B, 1, 1, 1);
        for (int i = 0; i < 20; i++) applyStimulus(8'h00, 0, 1, 1);
        applyStimulus("A", 1, 1, 1);
        applyStimulus(8'h00, 0, 1, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2: d = 8'($urandom_range(8'h20, 8'h7E));
                3, 4:    d = 8'h1B;
                5:       d = (($urandom % 2) == 0) ? 8'h59 : 8'h5A;
                6:       d = 8'($urandom_range(8'h41, 8'h4B));
                7:       d = 8'($urandom_range(8'h07, 8'h0D));
                default: d = 8'($urandom);
            endcase
            v = ($urandom % 4) != 0;
            r = ($urandom % 3) != 0;
            applyStimulus(d, v, r, 1);
        end
        applyStimulus(8'h00, 0, 1, 1);
        applyStimulus(8'h00, 0, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
